// File: rtl/pll_vga_lock_ctrl.sv
// Reset/lock sequencer for the VGA pixel PLL: holds the PLL in reset, qualifies lock, releases the VGA reset.
// Optional lock-loss glitch filter in RUN: define PLL_VGA_LOCK_FILTER_EN.
module pll_vga_lock_ctrl #(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 7,
  parameter int LOSS_FILTER_CYCLES  = 4
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_relock,
  output logic       pll_rst,
  output logic       vga_rst_n,
  output logic       ready,
  output logic       lock_lost,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXC = max2(max2(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES),
                             max2(LOCK_STABLE_CYCLES, LOSS_FILTER_CYCLES));
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [2:0] {
    S_RESET_PLL, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAIL
  } state_t;

  state_t          state, nxt_state;
  logic [CW-1:0]   cnt, nxt_cnt;
  logic [3:0]      nxt_retry;
  logic            nxt_lost;
  logic [1:0]      sync_q;
  logic            locked_s;

  assign locked_s = sync_q[1];

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], pll_locked};
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 1'b1;
    nxt_retry = retry_cnt;
    nxt_lost  = 1'b0;
    case (state)
      S_RESET_PLL: if (cnt == CW'(RST_HOLD_CYCLES - 1)) nxt_state = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (locked_s) nxt_state = S_STABLE;
        else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          if (retry_cnt == 4'(MAX_RETRIES)) nxt_state = S_FAIL;
          else begin
            nxt_retry = retry_cnt + 4'd1;
            nxt_state = S_RESET_PLL;
          end
        end
      end
      S_STABLE: begin
        if (!locked_s) nxt_state = S_WAIT_LOCK;
        else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
          nxt_state = S_RUN;
          nxt_retry = 4'd0;
        end
      end
`ifdef PLL_VGA_LOCK_FILTER_EN
      // In RUN the shared counter tracks consecutive unlocked samples.
      S_RUN: begin
        if (locked_s) nxt_cnt = '0;
        else if (cnt == CW'(LOSS_FILTER_CYCLES - 1)) begin
          nxt_state = S_RESET_PLL;
          nxt_lost  = 1'b1;
        end
      end
`else
      S_RUN: begin
        nxt_cnt = '0;
        if (!locked_s) begin
          nxt_state = S_RESET_PLL;
          nxt_lost  = 1'b1;
        end
      end
`endif
      S_FAIL:  nxt_cnt = '0;
      default: nxt_state = S_RESET_PLL;
    endcase
    // Software relock overrides any concurrent timeout or loss event.
    if (sw_relock && state != S_RESET_PLL) begin
      nxt_state = S_RESET_PLL;
      nxt_retry = 4'd0;
      nxt_lost  = 1'b0;
    end
    if (nxt_state != state) nxt_cnt = '0;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RESET_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      vga_rst_n <= 1'b0;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= 4'd0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      pll_rst   <= (nxt_state == S_RESET_PLL) || (nxt_state == S_FAIL);
      vga_rst_n <= (nxt_state == S_RUN);
      ready     <= (nxt_state == S_RUN);
      lock_lost <= nxt_lost;
      fail      <= (nxt_state == S_FAIL);
      retry_cnt <= nxt_retry;
    end
  end

endmodule

// File: tb/tb_pll_vga_lock_ctrl.sv
// Bench for pll_vga_lock_ctrl: directed timing checks plus random lock/relock traffic
// compared cycle by cycle against a phase/elapsed-time reference model.
module tb_pll_vga_lock_ctrl;
  localparam int H = 4, T = 32, S = 8, MR = 2, F = 4;
`ifdef PLL_VGA_LOCK_FILTER_EN
  localparam int F_EFF = F;
`else
  localparam int F_EFF = 1;
`endif
  localparam int EXIT = 1 + F_EFF;
  localparam logic [8:0] RST_VEC = 9'b1_0_0_0_0_0000;

  logic refclk = 1'b0, rst_n = 1'b1, pll_locked = 1'b0, sw_relock = 1'b0;
  logic pll_rst, vga_rst_n, ready, lock_lost, fail;
  logic [3:0] retry_cnt;
  logic [8:0] dut_vec;

  pll_vga_lock_ctrl #(.RST_HOLD_CYCLES(H), .LOCK_TIMEOUT_CYCLES(T), .LOCK_STABLE_CYCLES(S),
                      .MAX_RETRIES(MR), .LOSS_FILTER_CYCLES(F)) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .sw_relock(sw_relock),
    .pll_rst(pll_rst), .vga_rst_n(vga_rst_n), .ready(ready), .lock_lost(lock_lost),
    .fail(fail), .retry_cnt(retry_cnt));

  assign dut_vec = {pll_rst, vga_rst_n, ready, lock_lost, fail, retry_cnt};

  always #5 refclk = ~refclk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase plus cycles spent in it, lock seen through a 2-sample delay.
  localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAIL = 4;
  int m_ph, m_el, m_low, m_retry;
  bit m_lost, m_s1, m_ls;

  task model_reset();
    m_ph = P_RST; m_el = 0; m_low = 0; m_retry = 0; m_lost = 0; m_s1 = 0; m_ls = 0;
  endtask

  task goto(input int ph);
    m_ph = ph; m_el = 0; m_low = 0;
  endtask

  task model_step();
    m_lost = 0;
    if (sw_relock && m_ph != P_RST) begin
      goto(P_RST); m_retry = 0;
    end else begin
      case (m_ph)
        P_RST:  begin m_el++; if (m_el == H) goto(P_WAIT); end
        P_WAIT: begin
          if (m_ls) goto(P_STAB);
          else begin
            m_el++;
            if (m_el == T) begin
              if (m_retry == MR) goto(P_FAIL);
              else begin m_retry++; goto(P_RST); end
            end
          end
        end
        P_STAB: begin
          if (!m_ls) goto(P_WAIT);
          else begin m_el++; if (m_el == S) begin goto(P_RUN); m_retry = 0; end end
        end
        P_RUN: begin
          m_low = m_ls ? 0 : m_low + 1;
          if (m_low >= F_EFF) begin goto(P_RST); m_lost = 1; end
        end
        default: ;
      endcase
    end
    m_ls = m_s1;
    m_s1 = pll_locked;
  endtask

  function automatic logic [8:0] exp_vec();
    return {(m_ph == P_RST || m_ph == P_FAIL), (m_ph == P_RUN), (m_ph == P_RUN),
            m_lost, (m_ph == P_FAIL), 4'(m_retry)};
  endfunction

  task step();
    @(posedge refclk);
    model_step();
    @(negedge refclk);
    chk("outs", 16'(dut_vec), 16'(exp_vec()));
  endtask

  task relock_step();
    sw_relock = 1'b1;
    step();
    sw_relock = 1'b0;
  endtask

  task async_reset_check(input string tag);
    #1 rst_n = 1'b0;
    model_reset();
    #1 chk(tag, 16'(dut_vec), 16'(RST_VEC));
    @(negedge refclk);
    rst_n = 1'b1;
  endtask

  int nlost, hold;

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1 chk("reset_vals", 16'(dut_vec), 16'(RST_VEC));
    @(negedge refclk);
    rst_n = 1'b1;

    // Power-up: pll_rst held 4 cycles, lock 10 cycles after release, ready 10 cycles later.
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 3) chk("pll_rst_hold", 16'(pll_rst), 16'd1);
      if (i == 4) chk("pll_rst_release", 16'(pll_rst), 16'd0);
    end
    pll_locked = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (i == 10) chk("ready_early", 16'(ready), 16'd0);
      if (i == 11) begin
        chk("ready_rise", 16'(ready), 16'd1);
        chk("vga_rst_n_rise", 16'(vga_rst_n), 16'd1);
        chk("retry_after_lock", 16'(retry_cnt), 16'd0);
      end
    end

    // Sustained lock loss in RUN.
    nlost = 0;
    pll_locked = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      nlost += int'(lock_lost);
      if (i == EXIT) chk("run_hold", 16'(ready), 16'd1);
      if (i == EXIT + 1) begin
        chk("run_exit_ready", 16'(ready), 16'd0);
        chk("run_exit_vga", 16'(vga_rst_n), 16'd0);
        chk("run_exit_lost", 16'(lock_lost), 16'd1);
      end
      if (i == EXIT + 4) chk("relock_rst_hold", 16'(pll_rst), 16'd1);
      if (i == EXIT + 5) chk("relock_rst_rel", 16'(pll_rst), 16'd0);
    end
    chk("lost_pulses", 16'(nlost), 16'd1);
    pll_locked = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("back_in_run", 16'(ready), 16'd1);

    // Three-cycle glitch in RUN.
    nlost = 0;
    for (int i = 1; i <= 20; i++) begin
      pll_locked = !(i <= 3);
      step();
      nlost += int'(lock_lost);
    end
    chk("glitch_lost", 16'(nlost), 16'(F_EFF > 3 ? 0 : 1));
    for (int i = 0; i < 30; i++) step();
    chk("glitch_recover", 16'(ready), 16'd1);

    // No lock at all: two retries then FAIL; relock wins over RUN loss.
    pll_locked = 1'b0;
    relock_step();
    for (int i = 1; i <= 108; i++) begin
      step();
      if (i == 35)  chk("retry0", 16'(retry_cnt), 16'd0);
      if (i == 36)  chk("retry1", 16'(retry_cnt), 16'd1);
      if (i == 72)  chk("retry2", 16'(retry_cnt), 16'd2);
      if (i == 107) chk("fail_early", 16'(fail), 16'd0);
    end
    chk("fail_set", 16'(fail), 16'd1);
    chk("fail_pll_rst", 16'(pll_rst), 16'd1);
    relock_step();
    chk("relock_fail_clr", 16'(fail), 16'd0);
    chk("relock_retry_clr", 16'(retry_cnt), 16'd0);
    chk("relock_pll_rst", 16'(pll_rst), 16'd1);

    // One timeout, then a one-cycle dropout while STABLE count is 5.
    relock_step();
    for (int i = 1; i <= 60; i++) begin
      pll_locked = (i >= 41 && i != 47);
      step();
      if (i == 49) chk("stable_drop_retry", 16'(retry_cnt), 16'd1);
      if (i == 51) chk("stable_restarted", 16'(ready), 16'd0);
      if (i == 57) chk("stable_not_yet", 16'(ready), 16'd0);
      if (i == 58) begin
        chk("stable_run", 16'(ready), 16'd1);
        chk("stable_run_retry", 16'(retry_cnt), 16'd0);
      end
    end

    // Asynchronous reset in WAIT_LOCK with one retry spent.
    pll_locked = 1'b0;
    relock_step();
    for (int i = 1; i <= 42; i++) step();
    chk("pre_rst_retry", 16'(retry_cnt), 16'd1);
    async_reset_check("async_rst");

    // Random lock/relock traffic against the model.
    hold = 0;
    for (int c = 0; c < 2500; c++) begin
      if (hold == 0) begin
        pll_locked = ($urandom_range(0, 3) != 0);
        hold = int'($urandom_range(1, 50));
      end
      hold--;
      sw_relock = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 800) == 0) async_reset_check("rand_async_rst");
      step();
    end
    sw_relock = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pll_vga_lock_ctrl.md
# pll_vga_lock_ctrl

Reset/lock sequencer for the 50 MHz → 25 MHz VGA pixel PLL. It holds the PLL in reset after power-up, waits for a stable `locked`, and only then releases the VGA pipeline reset. If lock is lost or never acquired, it retries with a bounded count and reports failure. It sits in the `refclk` domain between the board reset and the PLL's `rst`/`locked` pins.

## Interface
- `RST_HOLD_CYCLES`, 16 — cycles `pll_rst` is held high per reset attempt (≥1).
- `LOCK_TIMEOUT_CYCLES`, 50000 — max cycles in WAIT_LOCK before retry (1 ms at 50 MHz).
- `LOCK_STABLE_CYCLES`, 1024 — consecutive synced-lock cycles required before RUN (≥1).
- `MAX_RETRIES`, 7 — retry attempts after the first before FAIL (≤15).
- `LOSS_FILTER_CYCLES`, 4 — lock-loss glitch filter length (≥1); used only with the macro.

Ports:
- `refclk` in 1 — 50 MHz reference clock; sole clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `pll_locked` in 1 — PLL `locked`; asynchronous, synchronized internally with 2 flops.
- `sw_relock` in 1 — one-cycle request to restart the sequence.
- `pll_rst` out 1 — drives PLL `rst`; active high.
- `vga_rst_n` out 1 — VGA pipeline reset, active low; downstream re-synchronizes it into the pixel domain.
- `ready` out 1 — high only in RUN.
- `lock_lost` out 1 — one-cycle pulse on leaving RUN due to lock loss.
- `fail` out 1 — high in FAIL.
- `retry_cnt` out 4 — retries used in the current sequence.

## Operation
- All outputs are registered and decoded from the next state, so they change on the same edge the state changes.
- Reset values: state RESET_PLL, counter 0, `pll_rst`=1, `vga_rst_n`=0, `ready`=0, `lock_lost`=0, `fail`=0, `retry_cnt`=0. Sync flops clear to 0.
- One shared counter, width `$clog2` of the largest cycle parameter plus 1. It clears on every state change.

States:
- **RESET_PLL** (`pll_rst`=1): count to RST_HOLD_CYCLES−1, then go to WAIT_LOCK. `sw_relock` is ignored here.
- **WAIT_LOCK** (`pll_rst`=0):
  - `locked_s`=1 → STABLE.
  - Else, if the counter reaches LOCK_TIMEOUT_CYCLES−1: if `retry_cnt`==MAX_RETRIES, go to FAIL; otherwise increment `retry_cnt` and go to RESET_PLL.
- **STABLE**:
  - `locked_s`=0 → WAIT_LOCK with a fresh timeout and no retry increment.
  - Counter reaches LOCK_STABLE_CYCLES−1 with `locked_s`=1 → RUN; `retry_cnt` clears to 0.
- **RUN** (`vga_rst_n`=1, `ready`=1): on lock loss, go to RESET_PLL. On that edge `lock_lost`=1 for one cycle, and `vga_rst_n`=0 and `ready`=0 on the same edge.
- **FAIL** (`pll_rst`=1, `fail`=1, `vga_rst_n`=0): exits only on `sw_relock` or `rst_n`.

`sw_relock` in any state except RESET_PLL → RESET_PLL, with `retry_cnt`=0 and `fail`=0. If it coincides with a lock-loss or timeout event, `sw_relock` wins and `lock_lost` is not pulsed.

`rst_n` asserted mid-sequence returns all outputs to their reset values immediately (asynchronous).

## Timing
- Let `pll_locked` rise before edge k. `locked_s`=1 after edge k+1, the state is STABLE at edge k+2, and `ready`/`vga_rst_n` rise at edge k+2+LOCK_STABLE_CYCLES.
- Let `pll_locked` fall before edge k in RUN (unfiltered). The exit from RUN happens at edge k+2.
- Each failed attempt costs exactly RST_HOLD_CYCLES + LOCK_TIMEOUT_CYCLES cycles.

## Configuration
- `PLL_VGA_LOCK_FILTER_EN` defined: RUN exits only after LOSS_FILTER_CYCLES consecutive `locked_s`=0 samples. The exit edge is k+1+LOSS_FILTER_CYCLES, and the filter count resets on any `locked_s`=1.
- Undefined: a single `locked_s`=0 sample in RUN triggers the exit, with no filter logic.
- STABLE behaviour is identical either way.

## Test plan
Bench parameters: RST_HOLD=4, TIMEOUT=32, STABLE=8, MAX_RETRIES=2, FILTER=4.

- Reset release with `pll_locked` rising 10 cycles later → `pll_rst` high for 4 cycles, then low; `ready`=`vga_rst_n`=1 exactly 10 cycles after the `pll_locked` edge; `retry_cnt`=0.
- `pll_locked` held 0 → `retry_cnt` steps 1, 2; `fail`=1 after 3×(4+32) cycles; `pll_rst`=1 in FAIL. Then `sw_relock` → RESET_PLL, `fail`=0, `retry_cnt`=0.
- In STABLE, drop `pll_locked` for 1 cycle at stable count 5 → return to WAIT_LOCK, `retry_cnt` unchanged, STABLE restarts from 0.
- In RUN, hold `pll_locked` low for 20 cycles → `lock_lost` pulses once, `vga_rst_n`/`ready` fall at k+2 (no macro) or k+5 (macro), `pll_rst`=1 for 4 cycles.
- With macro, 3-cycle low glitch in RUN → `ready` stays 1, `lock_lost` never asserts. Without macro, the same glitch causes a relock.
- Assert `rst_n`=0 mid-WAIT_LOCK with `retry_cnt`=1 → all outputs return to reset values within the same cycle, without waiting for a clock edge.
